// File: rtl/capture_seq_pkg.sv
// ============================================================================
// Module      : capture_seq_pkg
// Description : Shared types and constants for the capture sequencer: state
//               encoding, header beat layout and a header builder helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package capture_seq_pkg;

    // Sequencer states; the numeric encoding is visible on o_state.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        WAIT_TRIG = 3'd2,
        CAPTURE   = 3'd3,
        DRAIN     = 3'd4,
        DONE      = 3'd5
    } seq_state_e;

    localparam logic [7:0] HEADER_MAGIC = 8'hA5;

    // Header beat layout: {magic[31:24], 5'b0, timeout[18], overflow[17], 1'b1[16], count[15:0]}
    localparam int HDR_MAGIC_LSB    = 24;
    localparam int HDR_TIMEOUT_BIT  = 18;
    localparam int HDR_OVERFLOW_BIT = 17;
    localparam int HDR_MARK_BIT     = 16;
    localparam int HDR_COUNT_LSB    = 0;

    function automatic logic [31:0] make_header(input logic        timeout,
                                                input logic        overflow,
                                                input logic [15:0] count);
        logic [31:0] h;
        h                            = '0;
        h[HDR_MAGIC_LSB +: 8]        = HEADER_MAGIC;
        h[HDR_TIMEOUT_BIT]           = timeout;
        h[HDR_OVERFLOW_BIT]          = overflow;
        h[HDR_MARK_BIT]              = 1'b1;
        h[HDR_COUNT_LSB +: 16]       = count;
        return h;
    endfunction

endpackage

`default_nettype wire

// File: rtl/capture_sequencer_out_reg.sv
// ============================================================================
// Module      : seq_out_reg
// Description : 32-bit valid/ready output register. A load fills it; a beat
//               leaves when the consumer is ready. Load takes priority, so a
//               load in the same cycle as an accept replaces the word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_out_reg (
    input  logic        i_clk,
    input  logic        mrst,
    input  logic        i_load,
    input  logic [31:0] i_data,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [31:0] o_data
);

    logic        valid_q;
    logic [31:0] data_q;

    // Hold the word until accepted; a new load always wins.
    always_ff @(posedge i_clk) begin
        if (mrst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (i_load) begin
            valid_q <= 1'b1;
            data_q  <= i_data;
        end else if (valid_q && i_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule

`default_nettype wire

// File: rtl/capture_sequencer.sv
// ============================================================================
// Module      : capture_sequencer
// Description : Sequences one capture channel and its FIFO through arm,
//               trigger wait, capture and drain to a host valid/ready port.
//               Optional header beat on drain entry: CAPTURE_SEQ_HEADER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module capture_sequencer
    import capture_seq_pkg::*;
#(
    parameter int          RST_HOLD     = 8,
    parameter int          FIFO_DEPTH   = 256,
    parameter logic [31:0] TRIG_TIMEOUT = 32'd50_000_000,
    localparam int         CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             mrst,
    input  logic             i_arm,
    input  logic             i_abort,
    input  logic             i_run,
    input  logic             i_fifo_empty,
    input  logic             i_fifo_full,
    input  logic [31:0]      i_fifo_q,
    output logic             o_fifo_rd,
    output logic             o_fifo_clr,
    output logic             o_chan_rst_n,
    output logic [31:0]      o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_busy,
    output logic [2:0]       o_state,
    output logic             o_overflow,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_word_count
);

    localparam int                HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(FIFO_DEPTH);

    seq_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [31:0]       tmo_q, tmo_d;
    logic              overflow_q, overflow_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              rd_pend_q;
    logic              fifo_clr_q;

    logic              w_arm_take;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_load;
    logic [31:0]       w_load_data;
    logic              w_count_beat;
    logic [31:0]       w_tmo_next;

    assign w_arm_take = i_arm && (state_q == IDLE || state_q == DONE);
    assign w_accept   = w_out_valid && i_ready;
    assign w_tmo_next = tmo_q + 32'd1;

    // Next-state and per-round bookkeeping.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        tmo_d      = tmo_q;
        overflow_d = overflow_q;
        timeout_d  = timeout_q;
        word_cnt_d = word_cnt_q;
        if (w_arm_take) begin
            state_d    = ARM;
            hold_d     = '0;
            overflow_d = 1'b0;
            timeout_d  = 1'b0;
            word_cnt_d = '0;
        end else begin
            case (state_q)
                ARM: begin
                    if (i_abort) begin
                        state_d = IDLE;
                    end else if (hold_q == HOLD_LAST) begin
                        state_d = WAIT_TRIG;
                        tmo_d   = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                WAIT_TRIG: begin
                    tmo_d = w_tmo_next;
                    if (i_abort) begin
                        state_d = IDLE;
                    end else if (i_run) begin
                        state_d = CAPTURE;
                    end else if (TRIG_TIMEOUT != 32'd0 && w_tmo_next == TRIG_TIMEOUT) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end
                end
                CAPTURE: begin
                    if (i_fifo_full) begin
                        overflow_d = 1'b1;
                    end
                    if (i_abort) begin
                        state_d = IDLE;
                    end else if (!i_run) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    // Abort is deliberately not honoured here so no beat is lost.
                    if (w_count_beat && word_cnt_q != CNT_MAX) begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                    if (i_fifo_empty && !rd_pend_q && !w_out_valid) begin
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge i_clk) begin
        if (mrst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            tmo_q      <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            word_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            fifo_clr_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            tmo_q      <= tmo_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
            word_cnt_q <= word_cnt_d;
            rd_pend_q  <= o_fifo_rd;
            fifo_clr_q <= (state_d == ARM);
        end
    end

`ifdef CAPTURE_SEQ_HEADER_EN
    logic [15:0] hdr_cnt_q;
    logic        hdr_beat_q;
    logic        w_hdr_load;

    assign w_hdr_load = (state_q == CAPTURE) && (state_d == DRAIN);

    // Sample count for the header; the trigger cycle is the first sample.
    always_ff @(posedge i_clk) begin
        if (mrst) begin
            hdr_cnt_q  <= '0;
            hdr_beat_q <= 1'b0;
        end else begin
            if (w_arm_take) begin
                hdr_cnt_q <= '0;
            end else if ((state_q == CAPTURE || (state_q == WAIT_TRIG && state_d == CAPTURE))
                         && i_run && !i_fifo_full) begin
                hdr_cnt_q <= hdr_cnt_q + 16'd1;
            end
            if (w_hdr_load) begin
                hdr_beat_q <= 1'b1;
            end else if (w_accept) begin
                hdr_beat_q <= 1'b0;
            end
        end
    end

    assign w_load       = w_hdr_load || rd_pend_q;
    assign w_load_data  = w_hdr_load ? make_header(timeout_q, overflow_d, hdr_cnt_q) : i_fifo_q;
    assign w_count_beat = w_accept && !hdr_beat_q;
`else
    assign w_load       = rd_pend_q;
    assign w_load_data  = i_fifo_q;
    assign w_count_beat = w_accept;
`endif

    seq_out_reg u_out_reg (
        .i_clk   (i_clk),
        .mrst    (mrst),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_ready (i_ready),
        .o_valid (w_out_valid),
        .o_data  (o_data)
    );

    // One read in flight; the output register is free or emptying this cycle.
    assign o_fifo_rd    = (state_q == DRAIN) && !i_fifo_empty && !rd_pend_q
                          && (!w_out_valid || w_accept);
    assign o_fifo_clr   = fifo_clr_q;
    assign o_chan_rst_n = (state_q == WAIT_TRIG) || (state_q == CAPTURE) || (state_q == DRAIN);
    assign o_valid      = w_out_valid;
    assign o_busy       = (state_q != IDLE);
    assign o_state      = state_q;
    assign o_overflow   = overflow_q;
    assign o_timeout    = timeout_q;
    assign o_word_count = word_cnt_q;

endmodule

`default_nettype wire
